// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between the instruction fetch
// port (IF) and the data port (MEM). Data accesses win over fetches. Every
// access lasts WAIT_CYCLES+1 cycles, and all SRAM pins come straight from
// registers.
//
// Handshake: a requester raises *_REQ together with its address and data.
// The arbiter samples the request only in IDLE or on the final cycle of an
// access. That cycle is "cycle 0", and the access then occupies cycles 1..N.
// Completion is a one-cycle *_VALID pulse in cycle N+1. A request that is
// still high on a final cycle counts as a new access and is chained with no
// gap. A request may drop once it has been selected, and the selected access
// still completes.
//
// WAIT_CYCLES has a legal range of 1..7. The 3-bit counter runs from 0 up to
// WAIT_CYCLES, so it covers N = 2..8.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_DATA,
  output logic        IF_VALID,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_WDATA,
  input  logic [3:0]  MEM_BE,
  output logic [31:0] MEM_RDATA,
  output logic        MEM_VALID,
  output logic        STALL_REQ_STR,
  output logic [19:0] BASE_ADDR,
  output logic [31:0] BASE_DATA_O,
  input  logic [31:0] BASE_DATA_I,
  output logic        BASE_DATA_OE,
  output logic        BASE_CE_N,
  output logic        BASE_OE_N,
  output logic        BASE_WE_N,
  output logic [3:0]  BASE_BE_N,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  // Counter value in the final access cycle (cycle N), and in cycle N-1.
  // The write strobe is released at the end of cycle N-1.
  localparam logic [2:0] LAST_IDX = 3'(WAIT_CYCLES);
  localparam logic [2:0] WE_IDX   = 3'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        if_valid_q;
  logic        mem_valid_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_rdata_q;
  logic [19:0] addr_q;
  logic [31:0] data_o_q;
  logic        data_oe_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic [3:0]  be_n_q;
  logic        last_cycle;

  // Only word address bits [21:2] reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IF_ADDR[31:22], IF_ADDR[1:0],
                              MEM_ADDR[31:22], MEM_ADDR[1:0]};

  // High in cycle N of any access.
  assign last_cycle = (state_q != IDLE) && (cnt_q == LAST_IDX);

  // Structural stall: a data request is pending, or a data access is in flight.
  assign STALL_REQ_STR = MEM_REQ || (state_q == MEM_RD) || (state_q == MEM_WR);

  // Drive the outputs from registers.
  assign IF_DATA      = if_data_q;
  assign IF_VALID     = if_valid_q;
  assign MEM_RDATA    = mem_rdata_q;
  assign MEM_VALID    = mem_valid_q;
  assign BASE_ADDR    = addr_q;
  assign BASE_DATA_O  = data_o_q;
  assign BASE_DATA_OE = data_oe_q;
  assign BASE_CE_N    = ce_n_q;
  assign BASE_OE_N    = oe_n_q;
  assign BASE_WE_N    = we_n_q;
  assign BASE_BE_N    = be_n_q;
  assign DBG_STATE    = state_q;

  // Arbitration FSM: access sequencing, data capture, and registered SRAM pins.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      addr_q      <= 20'd0;
      data_o_q    <= 32'd0;
      data_oe_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
    end else begin
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;

      // Mid-access: advance the counter and end the write pulse one cycle early.
      if (state_q != IDLE && !last_cycle) begin
        cnt_q <= cnt_q + 3'd1;
        if (state_q == MEM_WR && cnt_q == WE_IDX) begin
          we_n_q <= 1'b1;
        end
      end

      // Final cycle: capture read data and schedule the completion pulse.
      if (last_cycle) begin
        case (state_q)
          IF_ACC: begin
            if_data_q  <= BASE_DATA_I;
            if_valid_q <= 1'b1;
          end
          MEM_RD: begin
            mem_rdata_q <= BASE_DATA_I;
            mem_valid_q <= 1'b1;
          end
          MEM_WR: mem_valid_q <= 1'b1;
          default: ;
        endcase
      end

      // Selection point: pick the next access, giving data priority over fetch.
      if (state_q == IDLE || last_cycle) begin
        cnt_q <= 3'd0;
        if (MEM_REQ) begin
          addr_q <= MEM_ADDR[21:2];
          ce_n_q <= 1'b0;
          if (MEM_WE) begin
            state_q   <= MEM_WR;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b0;
            be_n_q    <= ~MEM_BE;
            data_oe_q <= 1'b1;
            data_o_q  <= MEM_WDATA;
          end else begin
            state_q   <= MEM_RD;
            oe_n_q    <= 1'b0;
            we_n_q    <= 1'b1;
            be_n_q    <= 4'h0;
            data_oe_q <= 1'b0;
          end
        end else if (IF_REQ) begin
          state_q   <= IF_ACC;
          addr_q    <= IF_ADDR[21:2];
          ce_n_q    <= 1'b0;
          oe_n_q    <= 1'b0;
          we_n_q    <= 1'b1;
          be_n_q    <= 4'h0;
          data_oe_q <= 1'b0;
        end else begin
          state_q   <= IDLE;
          ce_n_q    <= 1'b1;
          oe_n_q    <= 1'b1;
          we_n_q    <= 1'b1;
          be_n_q    <= 4'hF;
          data_oe_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios followed by a randomized run. The
// randomized run is checked against a transaction-level model that tracks
// when the shared port is free and schedules each completion N+1 cycles
// after its selection cycle.
module tb_sram_arbiter;

  localparam int WAIT = 1;
  localparam int N    = WAIT + 1;
  localparam int R    = 400;

  logic        CLK;
  logic        RST;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic [31:0] IF_DATA;
  logic        IF_VALID;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_RDATA;
  logic        MEM_VALID;
  logic        STALL_REQ_STR;
  logic [19:0] BASE_ADDR;
  logic [31:0] BASE_DATA_O;
  logic [31:0] BASE_DATA_I;
  logic        BASE_DATA_OE;
  logic        BASE_CE_N;
  logic        BASE_OE_N;
  logic        BASE_WE_N;
  logic [3:0]  BASE_BE_N;
  logic [1:0]  DBG_STATE;

  int n_checks = 0;
  int n_err    = 0;

  // SRAM behavioural model (word indexed by the low 8 address bits)
  logic [31:0] sram [0:255];
  assign BASE_DATA_I = sram[BASE_ADDR[7:0]];

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:255];
  int          ev_kind [0:R+N+4];  // 0 none, 1 IF read, 2 MEM read, 3 MEM write
  bit          in_mem  [0:R+N+4];

  sram_arbiter #(.WAIT_CYCLES(WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_DATA(IF_DATA), .IF_VALID(IF_VALID),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE), .MEM_RDATA(MEM_RDATA),
    .MEM_VALID(MEM_VALID), .STALL_REQ_STR(STALL_REQ_STR),
    .BASE_ADDR(BASE_ADDR), .BASE_DATA_O(BASE_DATA_O), .BASE_DATA_I(BASE_DATA_I),
    .BASE_DATA_OE(BASE_DATA_OE), .BASE_CE_N(BASE_CE_N), .BASE_OE_N(BASE_OE_N),
    .BASE_WE_N(BASE_WE_N), .BASE_BE_N(BASE_BE_N), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver: apply any SRAM write seen this cycle, then move to the next cycle
  task automatic tick();
    if (!BASE_CE_N && !BASE_WE_N) begin
      for (int b = 0; b < 4; b++)
        if (!BASE_BE_N[b]) sram[BASE_ADDR[7:0]][8*b +: 8] = BASE_DATA_O[8*b +: 8];
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    IF_REQ = 0; MEM_REQ = 0; MEM_WE = 0;
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, "_ce"}, BASE_CE_N, 1);
    chk({tag, "_oe"}, BASE_OE_N, 1);
    chk({tag, "_we"}, BASE_WE_N, 1);
    chk({tag, "_be"}, BASE_BE_N, 4'hF);
    chk({tag, "_doe"}, BASE_DATA_OE, 0);
  endtask

  initial begin
    logic        mreq, mwe, ireq;
    logic [31:0] maddr, iaddr, mwd;
    logic [3:0]  mbe;
    logic [31:0] ref_if, ref_md, w;
    int          free_at, idx;

    RST = 0; IF_REQ = 0; MEM_REQ = 0; MEM_WE = 0;
    IF_ADDR = 0; MEM_ADDR = 0; MEM_WDATA = 0; MEM_BE = 0;
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[8'h04] = 32'h24020005;
    sram[8'h05] = 32'h11223344;
    sram[8'h10] = 32'hDEADBEEF;
    sram[8'h40] = 32'hA0A0A0A0;
    sram[8'h41] = 32'hA1A1A1A1;
    sram[8'h42] = 32'hA2A2A2A2;

    // reset held for two cycles
    tick(); tick();
    chk_inactive("rst");
    chk("rst_ifv", IF_VALID, 0);
    chk("rst_memv", MEM_VALID, 0);
    chk("rst_state", DBG_STATE, 2'd0);
    RST = 1;
    tick();

    // single fetch
    IF_REQ = 1; IF_ADDR = 32'h80000010; #1;
    chk("if_c0_stall", STALL_REQ_STR, 0);
    tick(); IF_REQ = 0; #1;
    chk("if_c1_addr", BASE_ADDR, 20'h00004);
    chk("if_c1_oe", BASE_OE_N, 0);
    chk("if_c1_ce", BASE_CE_N, 0);
    chk("if_c1_be", BASE_BE_N, 4'h0);
    chk("if_c1_stall", STALL_REQ_STR, 0);
    tick(); #1;
    chk("if_c2_oe", BASE_OE_N, 0);
    chk("if_c2_ifv", IF_VALID, 0);
    chk("if_c2_stall", STALL_REQ_STR, 0);
    tick(); #1;
    chk("if_c3_ifv", IF_VALID, 1);
    chk("if_c3_data", IF_DATA, 32'h24020005);
    chk("if_c3_memv", MEM_VALID, 0);
    chk("if_c3_stall", STALL_REQ_STR, 0);
    chk_inactive("if_c3");
    tick(); #1;
    chk("if_c4_ifv", IF_VALID, 0);

    // simultaneous IF and MEM read: data goes first
    IF_REQ = 1; IF_ADDR = 32'h80000014;
    MEM_REQ = 1; MEM_WE = 0; MEM_ADDR = 32'h00000040; #1;
    chk("pri_c0_stall", STALL_REQ_STR, 1);
    tick(); MEM_REQ = 0; #1;
    chk("pri_c1_stall", STALL_REQ_STR, 1);
    chk("pri_c1_addr", BASE_ADDR, 20'h00010);
    chk("pri_c1_oe", BASE_OE_N, 0);
    tick(); #1;
    chk("pri_c2_stall", STALL_REQ_STR, 1);
    tick(); IF_REQ = 0; #1;
    chk("pri_c3_memv", MEM_VALID, 1);
    chk("pri_c3_rdata", MEM_RDATA, 32'hDEADBEEF);
    chk("pri_c3_ifv", IF_VALID, 0);
    chk("pri_c3_addr", BASE_ADDR, 20'h00005);
    chk("pri_c3_stall", STALL_REQ_STR, 0);
    tick(); #1;
    chk("pri_c4_ifv", IF_VALID, 0);
    chk("pri_c4_memv", MEM_VALID, 0);
    tick(); #1;
    chk("pri_c5_ifv", IF_VALID, 1);
    chk("pri_c5_data", IF_DATA, 32'h11223344);

    // byte write
    MEM_REQ = 1; MEM_WE = 1; MEM_ADDR = 32'h80100003;
    MEM_BE = 4'b1000; MEM_WDATA = 32'hAB000000;
    tick(); idle_inputs(); #1;
    chk("wr_c1_addr", BASE_ADDR, 20'h40000);
    chk("wr_c1_be", BASE_BE_N, 4'b0111);
    chk("wr_c1_we", BASE_WE_N, 0);
    chk("wr_c1_oe", BASE_OE_N, 1);
    chk("wr_c1_doe", BASE_DATA_OE, 1);
    chk("wr_c1_dout", BASE_DATA_O, 32'hAB000000);
    chk("wr_c1_stall", STALL_REQ_STR, 1);
    tick(); #1;
    chk("wr_c2_we", BASE_WE_N, 1);
    chk("wr_c2_doe", BASE_DATA_OE, 1);
    chk("wr_c2_ce", BASE_CE_N, 0);
    tick(); #1;
    chk("wr_c3_memv", MEM_VALID, 1);
    chk("wr_c3_rdata_held", MEM_RDATA, 32'hDEADBEEF);
    chk_inactive("wr_c3");

    // three chained reads
    MEM_REQ = 1; MEM_WE = 0; MEM_ADDR = 32'h00000100;
    tick(); MEM_REQ = 0; #1;
    chk("b2b_c1_ce", BASE_CE_N, 0);
    tick(); MEM_REQ = 1; MEM_ADDR = 32'h00000104; #1;
    chk("b2b_c2_ce", BASE_CE_N, 0);
    tick(); MEM_REQ = 0; #1;
    chk("b2b_c3_ce", BASE_CE_N, 0);
    chk("b2b_c3_memv", MEM_VALID, 1);
    chk("b2b_c3_rdata", MEM_RDATA, 32'hA0A0A0A0);
    tick(); MEM_REQ = 1; MEM_ADDR = 32'h00000108; #1;
    chk("b2b_c4_ce", BASE_CE_N, 0);
    chk("b2b_c4_memv", MEM_VALID, 0);
    tick(); MEM_REQ = 0; #1;
    chk("b2b_c5_ce", BASE_CE_N, 0);
    chk("b2b_c5_memv", MEM_VALID, 1);
    chk("b2b_c5_rdata", MEM_RDATA, 32'hA1A1A1A1);
    tick(); #1;
    chk("b2b_c6_ce", BASE_CE_N, 0);
    chk("b2b_c6_memv", MEM_VALID, 0);
    tick(); #1;
    chk("b2b_c7_memv", MEM_VALID, 1);
    chk("b2b_c7_rdata", MEM_RDATA, 32'hA2A2A2A2);
    chk("b2b_c7_ce", BASE_CE_N, 1);

    // reset in cycle 1 of a fetch aborts it
    IF_REQ = 1; IF_ADDR = 32'h80000010;
    tick(); IF_REQ = 0; RST = 0;
    tick(); RST = 1; #1;
    chk_inactive("abort_c2");
    chk("abort_c2_ifv", IF_VALID, 0);
    chk("abort_c2_ifdata", IF_DATA, 0);
    chk("abort_c2_rdata", MEM_RDATA, 0);
    tick(); #1;
    chk("abort_c3_ifv", IF_VALID, 0);
    chk("abort_c3_memv", MEM_VALID, 0);

    // randomized traffic against the transaction-level model
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      sram[i] = w;
      ref_mem[i] = w;
    end
    for (int i = 0; i <= R + N + 4; i++) begin
      ev_kind[i] = 0;
      in_mem[i] = 0;
    end
    free_at = 0;
    ref_if = 32'h0;
    ref_md = 32'h0;
    for (int t = 0; t < R; t++) begin
      chk("rnd_ifv", IF_VALID, ev_kind[t] == 1);
      chk("rnd_memv", MEM_VALID, ev_kind[t] >= 2);
      if (ev_kind[t] == 1) ref_if = exp_q.pop_front();
      if (ev_kind[t] == 2) ref_md = exp_q.pop_front();
      chk("rnd_ifdata", IF_DATA, ref_if);
      chk("rnd_rdata", MEM_RDATA, ref_md);

      mreq  = ($urandom_range(0, 2) == 0);
      mwe   = $urandom_range(0, 1);
      ireq  = $urandom_range(0, 1);
      maddr = $urandom & 32'hFFC003FF;
      iaddr = $urandom & 32'hFFC003FF;
      mwd   = $urandom;
      mbe   = 4'($urandom_range(0, 15));
      MEM_REQ = mreq; MEM_WE = mwe; MEM_ADDR = maddr;
      MEM_WDATA = mwd; MEM_BE = mbe;
      IF_REQ = ireq; IF_ADDR = iaddr;

      if (t >= free_at) begin
        if (mreq) begin
          idx = int'(maddr[9:2]);
          if (mwe) begin
            for (int b = 0; b < 4; b++)
              if (mbe[b]) ref_mem[idx][8*b +: 8] = mwd[8*b +: 8];
            ev_kind[t + N + 1] = 3;
          end else begin
            exp_q.push_back(ref_mem[idx]);
            ev_kind[t + N + 1] = 2;
          end
          for (int k = 1; k <= N; k++) in_mem[t + k] = 1;
          free_at = t + N;
        end else if (ireq) begin
          exp_q.push_back(ref_mem[int'(iaddr[9:2])]);
          ev_kind[t + N + 1] = 1;
          free_at = t + N;
        end else begin
          free_at = t + 1;
        end
      end
      #1;
      chk("rnd_stall", STALL_REQ_STR, mreq | in_mem[t]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
